debounce_multi: RTL
===================

Name: debounce_multi

Overview:
- Parametrised N-channel pushbutton/switch debouncer.
- Replaces the single-channel two-flop debouncer driven by a fixed counter bit.
- Shared programmable sample-tick prescaler, per-channel synchroniser, per-channel stability counter.
- Outputs per channel: clean level, one-clk rise pulse, one-clk fall pulse. Sits between board pins and the control/velocity-curve logic.

Parameters:
- NCH, 4, number of independent input channels (1..32)
- DIV, 256, clk cycles per sample tick (>=2)
- STABLE, 4, consecutive ticks an input must disagree with current level before level changes (1..255)
- RST_LEVEL, 0, reset value of every debounced level bit (0 or 1)

Ports:
- clk  in  1  system clock; all flops on rising edge
- rst_n  in  1  asynchronous active-low reset, release synchronised by the integrator
- pb_in  in  NCH  raw asynchronous button inputs
- en  in  1  sampling enable; 0 freezes prescaler and stability counters
- pb_level  out  NCH  debounced level
- pb_rise  out  NCH  one-clk pulse on debounced 0->1
- pb_fall  out  NCH  one-clk pulse on debounced 1->0
- tick  out  1  sample strobe, one clk wide, for debug/other consumers

Behaviour:
- Reset (rst_n=0, async):
  - prescaler=0; tick=0
  - sync flops = RST_LEVEL
  - stability counters=0
  - pb_level = {NCH{RST_LEVEL}}
  - pb_rise = pb_fall = 0
- Synchroniser: two flops per channel on clk, always running (not gated by en). Output is sync[i].
- Prescaler:
  - Width ceil(log2(DIV)); counts 0..DIV-1 while en=1, wraps to 0.
  - tick=1 for exactly the clk where count==DIV-1 and en=1; period DIV clks.
  - en=0: count holds, tick=0.
- Per channel i, evaluated only on tick:
  - sync[i]==pb_level[i]: cnt[i] <= 0.
  - sync[i]!=pb_level[i] and cnt[i]==STABLE-1: pb_level[i] toggles, cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - cnt width ceil(log2(STABLE+1)); never exceeds STABLE-1.
- Glitch rejection: any single tick that agrees with the current level restarts the count. A bounce shorter than STABLE ticks never changes pb_level.
- Edge pulses:
  - Registered, asserted the clk after pb_level changes, exactly one clk wide.
  - pb_rise[i]&pb_fall[i] is never 1.
  - Channels are fully independent; simultaneous changes on several channels pulse in the same clk.
- Latency: from a stable pb_in change to pb_level change is 2 clk (sync) plus STABLE..STABLE+1 ticks, i.e. at most 2+DIV*(STABLE+1) clks. Edge pulse follows 1 clk later.
- STABLE=1: level follows the first disagreeing tick sample.
- Reset mid-operation: all state returns to reset values immediately. No edge pulse is generated by reset or by its release.
- en toggling: counters and level hold across en=0. Synchroniser keeps tracking. Resuming en continues from the held state.

Optional Feature:
- Macro DEBOUNCE_REPEAT_EN.
- Defined:
  - Adds parameter REPEAT_TICKS (default 64) and a per-channel repeat counter.
  - While pb_level[i]=1, pb_rise[i] re-pulses one clk every REPEAT_TICKS ticks after the initial rise (auto-repeat for held buttons).
  - The counter clears when pb_level[i] goes 0 or on reset.
  - pb_fall is unaffected.
- Not defined: no repeat logic; pb_rise pulses only on the debounced 0->1 transition.

Test Plan:
- Reset: NCH=4, RST_LEVEL=0, pb_in=4'hF during rst_n=0 -> pb_level=0, pb_rise=pb_fall=0 and tick=0 throughout reset; no pulse at release.
- Clean press: DIV=4, STABLE=3, pb_in[0] 0->1 held -> pb_level[0]=1 within 2+4*4=18 clks and not before 3 ticks; pb_rise[0] single 1-clk pulse the following clk; other channels unchanged.
- Bounce reject: pb_in[1] high for 2 ticks, low 1 tick, repeated 5 times -> pb_level[1] stays 0, no pb_rise/pb_fall.
- Release plus simultaneity: channels 0 and 2 held high, both released at the same clk -> pb_fall[0] and pb_fall[2] pulse in the same clk; pb_level returns to 0.
- en freeze: deassert en mid-count (cnt=2 of 3) for 50 clks with pb_in stable -> no tick, pb_level unchanged; on re-enable, change completes after 1 more tick.
- DEBOUNCE_REPEAT_EN, REPEAT_TICKS=2, DIV=4: hold pb_in[3]=1 for 40 clks after the debounced rise -> pb_rise[3] re-pulses every 8 clks; without the macro, exactly one pulse.

Source files
------------

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
// N-channel pushbutton/switch debouncer. A shared programmable prescaler
// produces a sample tick. Each channel has a two-flop synchroniser and a
// stability counter. A channel's debounced level only flips after the
// synchronised input has disagreed with it on STABLE consecutive ticks.
//
// Optional feature (compile-time macro DEBOUNCE_REPEAT_EN):
//   When defined, this adds parameter REPEAT_TICKS and a per-channel repeat
//   counter. While a channel's level is held at 1, pb_rise re-pulses every
//   REPEAT_TICKS ticks (auto-repeat).
//
// Ports:
//   clk       in   1    system clock, rising edge
//   rst_n     in   1    asynchronous active-low reset
//   pb_in     in   NCH  raw asynchronous button inputs
//   en        in   1    sampling enable (0 freezes prescaler and counters)
//   pb_level  out  NCH  debounced level
//   pb_rise   out  NCH  one-clk pulse after a debounced 0->1
//   pb_fall   out  NCH  one-clk pulse after a debounced 1->0
//   tick      out  1    sample strobe, high while count==DIV-1 and en=1
// -----------------------------------------------------------------------------
module debounce_multi #(
    parameter int NCH          = 4,
    parameter int DIV          = 256,
    parameter int STABLE       = 4,
    parameter int RST_LEVEL    = 0
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int REPEAT_TICKS = 64
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] pb_in,
    input  logic           en,
    output logic [NCH-1:0] pb_level,
    output logic [NCH-1:0] pb_rise,
    output logic [NCH-1:0] pb_fall,
    output logic           tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [PW-1:0]  PRE_LAST    = PW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_LAST    = CW'(STABLE - 1);
    localparam logic [NCH-1:0] RST_VEC     = (RST_LEVEL != 0) ? {NCH{1'b1}} : {NCH{1'b0}};

    logic [PW-1:0]  pre_q, pre_d;
    logic           tick_s;
    logic [NCH-1:0] sync1_q, sync2_q;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] level_q, level_d;
    logic [NCH-1:0] prev_q;
    logic [NCH-1:0] rise_q, rise_d;
    logic [NCH-1:0] fall_q, fall_d;

    // The tick is decoded from the prescaler register and qualified by en,
    // so it goes low in the very clk en is dropped.
    assign tick_s = en && (pre_q == PRE_LAST);

    // Prescaler next state: free-running modulo-DIV count while enabled.
    always_comb begin
        pre_d = pre_q;
        if (en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = {PW{1'b0}};
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end else begin
            pre_d = pre_q;
        end
    end

    // Per-channel stability counter and level update, evaluated on tick only.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick_s) begin
                if (sync2_q[i] == level_q[i]) begin
                    // Any agreeing sample restarts the stability window.
                    cnt_d[i] = {CW{1'b0}};
                end else if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                    cnt_d[i]   = {CW{1'b0}};
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

    logic [RW-1:0]  rep_q [NCH];
    logic [RW-1:0]  rep_d [NCH];
    logic [NCH-1:0] rep_fire_q, rep_fire_d;

    // Repeat counter: counts ticks while the level stays high. Requiring the
    // level to stay high through the tick keeps a repeat from overlapping a fall.
    always_comb begin
        rep_fire_d = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            rep_d[i] = rep_q[i];
            if (!level_q[i]) begin
                rep_d[i] = {RW{1'b0}};
            end else if (tick_s && level_d[i]) begin
                if (rep_q[i] == REP_LAST) begin
                    rep_d[i]      = {RW{1'b0}};
                    rep_fire_d[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + RW'(1);
                end
            end else begin
                rep_d[i] = rep_q[i];
            end
        end
    end

    // Repeat counter and repeat-fire registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_fire_q <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                rep_q[i] <= {RW{1'b0}};
            end
        end else begin
            rep_fire_q <= rep_fire_d;
            for (int i = 0; i < NCH; i++) begin
                rep_q[i] <= rep_d[i];
            end
        end
    end
`endif

    // Edge detect against the previous level. Because prev resets with the
    // level, neither reset nor its release can create a pulse.
    always_comb begin
`ifdef DEBOUNCE_REPEAT_EN
        rise_d = (level_q & ~prev_q) | rep_fire_q;
`else
        rise_d = level_q & ~prev_q;
`endif
        fall_d = ~level_q & prev_q;
    end

    // State registers: prescaler, synchroniser, counters, level, edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= {PW{1'b0}};
            sync1_q <= RST_VEC;
            sync2_q <= RST_VEC;
            level_q <= RST_VEC;
            prev_q  <= RST_VEC;
            rise_q  <= {NCH{1'b0}};
            fall_q  <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            pre_q   <= pre_d;
            sync1_q <= pb_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pb_level = level_q;
    assign pb_rise  = rise_q;
    assign pb_fall  = fall_q;
    assign tick     = tick_s;

endmodule
